hello_world_checker: RTL and testbench

//  Receive end of the 8-bit ASCII letter stream made by the "Hello World!" generator.

---
 rtl/hello_pkg.sv | 18 +
 rtl/hello_rom.sv | 29 ++
 rtl/hello_world_checker.sv | 118 +++++++++++
 tb/tb_hello_world_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
// Shared definitions for the "Hello World!" generator and checker.
package hello_pkg;

   localparam int unsigned MSG_LEN = 12;

   localparam logic [7:0] CH_H     = 8'd72;
   localparam logic [7:0] CH_E     = 8'd101;
   localparam logic [7:0] CH_L     = 8'd108;
   localparam logic [7:0] CH_O     = 8'd111;
   localparam logic [7:0] CH_SPACE = 8'd32;
   localparam logic [7:0] CH_W     = 8'd87;
   localparam logic [7:0] CH_R     = 8'd114;
   localparam logic [7:0] CH_D     = 8'd100;
   localparam logic [7:0] CH_BANG  = 8'd33;

   typedef enum logic [1:0] {IDLE, HUNT, MATCH, DONE} state_t;

endpackage

// File: rtl/hello_rom.sv
// Combinational message position -> expected ASCII character lookup.
module hello_rom #(
   parameter int unsigned IDX_W = 4
) (
   input  logic [IDX_W-1:0] _index,
   output logic [7:0]       _letter
);
   import hello_pkg::*;

   always_comb begin
      _letter = '0;
      case (int'(_index))
         0:       _letter = CH_H;
         1:       _letter = CH_E;
         2:       _letter = CH_L;
         3:       _letter = CH_L;
         4:       _letter = CH_O;
         5:       _letter = CH_SPACE;
         6:       _letter = CH_W;
         7:       _letter = CH_O;
         8:       _letter = CH_R;
         9:       _letter = CH_L;
         10:      _letter = CH_D;
         11:      _letter = CH_BANG;
         default: _letter = '0;
      endcase
   end

endmodule

// File: rtl/hello_world_checker.sv
// Receive-side checker for the "Hello World!" stream: tracks message position,
// pulses on full match or broken partial match, and counts complete messages.
module hello_world_checker #(
   parameter int unsigned MSG_LEN = hello_pkg::MSG_LEN,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned COUNT_W = 8
) (
   input  logic               _clock,
   input  logic               _reset,
   input  logic               _enable,
   input  logic               _valid,
   input  logic [7:0]         _letter,
   output logic               _ready,
   output logic               _match,
   output logic               _error,
   output logic [IDX_W-1:0]   _index,
   output logic [COUNT_W-1:0] _match_count
);
   import hello_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               match_q, match_d;
   logic               error_q, error_d;
   logic [COUNT_W-1:0] count_q;
   logic [7:0]         expected;
   logic               accept;

   hello_rom #(.IDX_W(IDX_W)) u_rom (
      ._index  (idx_q),
      ._letter (expected)
   );

   always_ff @(posedge _clock) begin
      if (!_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         match_q <= 1'b0;
         error_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         match_q <= match_d;
         error_q <= error_d;
         if (match_d && (count_q != '1))
            count_q <= count_q + 1'b1;
      end
   end

   assign accept = _valid && _ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      match_d = 1'b0;
      error_d = 1'b0;
      case (state_q)
         IDLE: begin
            idx_d = '0;
            if (_enable) state_d = HUNT;
         end
         HUNT: begin
            idx_d = '0;
            if (!_enable) begin
               state_d = IDLE;
            end else if (accept && (_letter == CH_H)) begin
               state_d = MATCH;
               idx_d   = IDX_W'(1);
            end
         end
         MATCH: begin
            if (!_enable) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (accept) begin
               if (_letter == expected) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = DONE;
                     idx_d   = '0;
                     match_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  // A broken message may itself be the start of the next one.
                  error_d = 1'b1;
                  if (_letter == CH_H) begin
                     idx_d = IDX_W'(1);
                  end else begin
                     state_d = HUNT;
                     idx_d   = '0;
                  end
               end
            end
         end
         DONE: begin
            idx_d   = '0;
            state_d = _enable ? HUNT : IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      _ready       = _reset && _enable && ((state_q == HUNT) || (state_q == MATCH));
      _match       = match_q;
      _error       = error_q;
      _index       = idx_q;
      _match_count = count_q;
   end

endmodule

// File: tb/tb_hello_world_checker.sv
// Scoreboard bench for hello_world_checker (COUNT_W=2 to reach saturation).
module tb_hello_world_checker;

   localparam int unsigned IDX_W   = 4;
   localparam int unsigned COUNT_W = 2;
   localparam int          SAT     = (1 << COUNT_W) - 1;

   typedef struct {
      int kind;   // 1 = match, 2 = error
      int idx;
      int cnt;
   } pulse_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic               valid = 1'b0;
   logic [7:0]         letter = '0;
   logic               ready;
   logic               match;
   logic               error;
   logic [IDX_W-1:0]   index;
   logic [COUNT_W-1:0] match_count;

   int n_checks = 0;
   int n_errors = 0;
   int mpos = 0;
   int mcnt = 0;
   pulse_t sb[$];

   byte unsigned msg [12] = '{72, 101, 108, 108, 111, 32, 87, 111, 114, 108, 100, 33};

   hello_world_checker #(.MSG_LEN(12), .IDX_W(IDX_W), .COUNT_W(COUNT_W)) dut (
      ._clock       (clk),
      ._reset       (rst_n),
      ._enable      (enable),
      ._valid       (valid),
      ._letter      (letter),
      ._ready       (ready),
      ._match       (match),
      ._error       (error),
      ._index       (index),
      ._match_count (match_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_accept(input byte unsigned c);
      pulse_t e;
      if (mpos == 0) begin
         if (c == 8'd72) mpos = 1;
      end else if (c == msg[mpos]) begin
         mpos++;
         if (mpos == 12) begin
            mcnt = (mcnt < SAT) ? mcnt + 1 : SAT;
            e.kind = 1; e.idx = 0; e.cnt = mcnt;
            sb.push_back(e);
            mpos = 0;
         end
      end else begin
         e.kind = 2; e.idx = (c == 8'd72) ? 1 : 0; e.cnt = mcnt;
         sb.push_back(e);
         mpos = e.idx;
      end
   endtask

   task automatic send_char(input byte unsigned c);
      int n = 0;
      valid  = 1'b1;
      letter = c;
      @(negedge clk);
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check_eq("ready_timeout", 32'(ready), 1);
      else model_accept(c);
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic send_msg();
      for (int i = 0; i < 12; i++) send_char(msg[i]);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; valid = 1'b0;
      idle_cycles(2);
      sb.delete();
      mpos = 0;
      mcnt = 0;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      idle_cycles(3);
      check_eq(tag, sb.size(), 0);
      sb.delete();
   endtask

   always @(negedge clk) begin
      pulse_t e;
      if (match || error) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_pulse", {30'd0, match, error}, 0);
         end else begin
            e = sb.pop_front();
            check_eq("pulse_kind", {30'd0, match, error}, (e.kind == 1) ? 2 : 1);
            if (e.kind == 1) begin
               check_eq("ready_in_done", 32'(ready), 0);
               check_eq("match_count", 32'(match_count), e.cnt);
            end else begin
               check_eq("error_index", 32'(index), e.idx);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset with a live beat presented
      rst_n = 1'b0; enable = 1'b1; valid = 1'b1; letter = 8'd72;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_ready", 32'(ready), 0);
         check_eq("rst_match", 32'(match), 0);
         check_eq("rst_error", 32'(error), 0);
         check_eq("rst_index", 32'(index), 0);
         check_eq("rst_count", 32'(match_count), 0);
      end
      do_reset();

      // 2: clean message
      enable = 1'b1;
      send_msg();
      drain("clean_pending");
      check_eq("clean_count", 32'(match_count), 1);

      // 3: resync on an early 'H'
      do_reset();
      enable = 1'b1;
      send_char(72); send_char(101); send_char(108); send_char(72);
      for (int i = 1; i < 12; i++) send_char(msg[i]);
      drain("resync_pending");
      check_eq("resync_count", 32'(match_count), 1);

      // 4: noise in HUNT, then a message with gaps
      do_reset();
      enable = 1'b1;
      for (int c = 0; c < 8'h48; c++) send_char(8'(c));
      check_eq("noise_index", 32'(index), 0);
      for (int i = 0; i < 12; i++) begin
         send_char(msg[i]);
         for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            check_eq("gap_index", 32'(index), mpos);
            @(posedge clk);
            #1;
         end
      end
      drain("gap_pending");
      check_eq("gap_count", 32'(match_count), 1);

      // 5: enable drop mid-message, beat presented that cycle is dropped
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 5; i++) send_char(msg[i]);
      check_eq("pre_drop_index", 32'(index), 5);
      enable = 1'b0; valid = 1'b1; letter = 8'd32;
      @(posedge clk);
      #1;
      valid = 1'b0;
      mpos = 0;
      @(negedge clk);
      check_eq("drop_index", 32'(index), 0);
      check_eq("drop_ready", 32'(ready), 0);
      check_eq("drop_error", 32'(error), 0);
      enable = 1'b1;
      send_msg();
      drain("drop_pending");
      check_eq("drop_count", 32'(match_count), 1);

      // 6: saturation, 5 back-to-back messages
      do_reset();
      enable = 1'b1;
      for (int m = 0; m < 5; m++) send_msg();
      drain("sat_pending");
      check_eq("sat_count", 32'(match_count), SAT);

      // reset after 7 chars
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 7; i++) send_char(msg[i]);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_rst_ready", 32'(ready), 0);
      check_eq("mid_rst_match", 32'(match), 0);
      check_eq("mid_rst_error", 32'(error), 0);
      check_eq("mid_rst_index", 32'(index), 0);
      check_eq("mid_rst_count", 32'(match_count), 0);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
